// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch / next-PC controller for the 8-bit microprocessor.
//
// Drives the free-running pc register (which loads next_pc on every edge) and
// walks each instruction through FETCH -> EXEC, choosing the next PC when the
// datapath signals completion. A halting instruction parks the sequencer in
// HALT until reset.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cur_pc            current PC from pc.NextO
//   next_pc           next PC to pc.NextI (combinational)
//   imem_req/addr     fetch request and address (address == cur_pc)
//   imem_ack/data     fetch acknowledge and instruction byte
//   instr/instr_valid registered instruction, high while executing
//   exec_done         datapath finished; qualifies branch_taken/jump/halt
//   branch_taken/off  relative branch, two's-complement offset
//   jump/jump_addr    absolute jump
//   halt/halted       halt request / sequencer parked in HALT
//   retired           saturating count of completed instructions
module pc_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       cur_pc,
    output logic [7:0]       next_pc,
    output logic             imem_req,
    output logic [7:0]       imem_addr,
    input  logic             imem_ack,
    input  logic [7:0]       imem_data,
    output logic [7:0]       instr,
    output logic             instr_valid,
    input  logic             exec_done,
    input  logic             branch_taken,
    input  logic [7:0]       branch_off,
    input  logic             jump,
    input  logic [7:0]       jump_addr,
    input  logic             halt,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [7:0]       instrQ;
    logic [CNT_W-1:0] retiredQ;
    logic [7:0]       pcInc;
    logic [7:0]       branchTgt;
    logic             doneExec;

    // Adding the 8-bit offset modulo 256 is the same as adding its sign
    // extension, so no explicit extension is needed.
    assign pcInc     = cur_pc + 8'd1;
    assign branchTgt = pcInc + branch_off;
    assign doneExec  = (state == EXEC) && exec_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else
            state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            FETCH:   if (imem_ack) stateNext = EXEC;
            EXEC:    if (exec_done) stateNext = halt ? HALT : FETCH;
            HALT:    stateNext = HALT;
            default: stateNext = FETCH;
        endcase
    end

    // Output logic; reset overrides everything so pc loads 0 on the reset edge.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        next_pc     = cur_pc;
        if (reset) begin
            next_pc = 8'h00;
        end else begin
            case (state)
                FETCH: imem_req = 1'b1;
                EXEC: begin
                    instr_valid = 1'b1;
                    if (exec_done) begin
                        if (halt)
                            next_pc = cur_pc;
                        else if (jump)
                            next_pc = jump_addr;
                        else if (branch_taken)
                            next_pc = branchTgt;
                        else
                            next_pc = pcInc;
                    end
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

    // Instruction latch and retired counter
    always_ff @(posedge clk) begin
        if (reset) begin
            instrQ   <= 8'h00;
            retiredQ <= '0;
        end else begin
            if (state == FETCH && imem_ack)
                instrQ <= imem_data;
            if (doneExec && (retiredQ != {CNT_W{1'b1}}))
                retiredQ <= retiredQ + 1'b1;
        end
    end

    assign imem_addr = cur_pc;
    assign instr     = instrQ;
    assign retired   = retiredQ;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/next-PC controller for the 8-bit microprocessor. It drives the `NextI` input of the free-running `pc` register, which loads on every `clk` edge and has no enable or reset, and it receives the register's `NextO` back as `cur_pc`. It fetches each instruction from instruction memory with a request/acknowledge handshake, then holds the instruction for the datapath until execution completes. It then selects the next PC: increment, relative branch or absolute jump, or halts.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cur_pc`  in  8  current PC, from `pc.NextO`.
- `next_pc`  out  8  next PC, to `pc.NextI`; combinational.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  8  fetch address; always equals `cur_pc`.
- `imem_ack`  in  1  fetch data valid this cycle.
- `imem_data`  in  8  fetched instruction.
- `instr`  out  8  registered current instruction.
- `instr_valid`  out  1  `instr` is valid and executing.
- `exec_done`  in  1  datapath finished the current instruction.
- `branch_taken`  in  1  take a relative branch; sampled with `exec_done`.
- `branch_off`  in  8  two's-complement branch offset.
- `jump`  in  1  take an absolute jump; sampled with `exec_done`.
- `jump_addr`  in  8  jump target.
- `halt`  in  1  stop after the current instruction; sampled with `exec_done`.
- `halted`  out  1  sequencer is in HALT.
- `retired`  out  `CNT_W`  count of completed instructions, saturating.

## Operation
- States: FETCH, EXEC, HALT. After reset the state is FETCH.
- FETCH:
  - `imem_req`=1.
  - On `imem_ack`=1: `instr`<=`imem_data`, go to EXEC.
  - Otherwise stay in FETCH.
  - `next_pc`=`cur_pc` (hold).
- EXEC:
  - `instr_valid`=1.
  - Without `exec_done`: `next_pc`=`cur_pc`, stay in EXEC.
  - On `exec_done`=1, `next_pc` by priority:
    - `halt` → `cur_pc`, go to HALT.
    - else `jump` → `jump_addr`.
    - else `branch_taken` → `cur_pc + 1 + sext(branch_off)`.
    - else `cur_pc + 1`.
  - For every case except `halt`, go to FETCH.
  - `retired` += 1 on every `exec_done`, including a halting one; it saturates at all-ones.
- HALT:
  - `halted`=1, `next_pc`=`cur_pc`.
  - `imem_req`=0, `instr_valid`=0.
  - Exit only through reset.
- Arithmetic is 8-bit modulo 256. Wrap-around is silent: 0xFF+1=0x00, and 0x02+1+(-8)=0xFB.
- `imem_ack` is ignored outside FETCH. `exec_done`, `jump`, `branch_taken` and `halt` are ignored outside EXEC.
- `instr` keeps its value in EXEC and HALT. It changes only on an accepted fetch.

## Timing
- While `reset`=1:
  - `next_pc`=0x00 (combinational), so `pc` loads 0x00 on the reset edge.
  - `imem_req`=0, `instr_valid`=0, `halted`=0.
- On each reset edge: state<=FETCH, `instr`<=0x00, `retired`<=0.
- Reset must be held for at least one `clk` edge.
- Reset asserted mid-fetch or mid-exec aborts the operation. The pending fetch is dropped, and an `imem_ack` arriving during reset is ignored.
- Fetch with zero-wait memory: `imem_ack` in the first FETCH cycle puts `instr_valid` high on the next cycle.
- Each extra wait cycle adds one cycle of latency. `imem_req` stays high and `imem_addr` stays stable until ack.
- The PC update takes effect at the edge where `exec_done`=1. The following FETCH cycle sees the new `cur_pc` on `imem_addr`.
- Minimum instruction period is 2 cycles: FETCH with immediate ack, then EXEC with immediate `exec_done`.
- Jump and branch asserted together: jump wins. Halt asserted with jump or branch: halt wins and the PC is not changed.

## Test plan
- Reset, then zero-wait ack and immediate `exec_done` each instruction → `imem_addr` 0x00, 0x01, 0x02 on successive FETCH cycles, one instruction per 2 cycles, `retired`=3 after three instructions.
- Ack delayed 2 cycles at PC 0x05 with `imem_data`=0x3C → `imem_req` high for 3 cycles with `imem_addr`=0x05 throughout, `instr`=0x3C, `instr_valid` rises the cycle after ack, PC held at 0x05 throughout.
- At PC 0x10, `branch_taken`=1, `branch_off`=0xFD (-3) → next fetch address 0x0E. Same cycle with `jump`=1 and `jump_addr`=0xA0 → 0xA0 instead.
- At PC 0xFF, plain `exec_done` → next fetch 0x00. At PC 0x02 with branch offset 0xF8 → 0xFB.
- `halt`=1 with `exec_done` at PC 0x22 → `halted`=1, `next_pc` stays 0x22 indefinitely, no `imem_req`, `retired` incremented once. Acks and `exec_done` pulses in HALT → no effect.
- `reset` asserted while waiting for ack at PC 0x40, with `imem_ack` pulsed during reset → PC becomes 0x00, `instr`=0x00, fetch restarts at 0x00 after release, and the stale ack is not captured.
